// File: rtl/adc_snapshot_buffer_if.sv
// Bundles the ADC AXI4-Stream input and the 32-bit read-back port of the snapshot buffer.
interface adc_snapshot_buffer_if #(
  parameter int DATA_WIDTH    = 128,
  parameter int RD_ADDR_WIDTH = 12
);
  logic [DATA_WIDTH-1:0]    s_axis_tdata;
  logic                     s_axis_tvalid;
  logic                     s_axis_tready;
  logic                     rd_en_i;
  logic [RD_ADDR_WIDTH-1:0] rd_addr_i;
  logic [31:0]              rd_data_o;
  logic                     rd_valid_o;

  modport master (
    output s_axis_tdata, s_axis_tvalid, rd_en_i, rd_addr_i,
    input  s_axis_tready, rd_data_o, rd_valid_o
  );

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, rd_en_i, rd_addr_i,
    output s_axis_tready, rd_data_o, rd_valid_o
  );
endinterface

// File: rtl/adc_snapshot_buffer.sv
// Captures DEPTH consecutive ADC stream beats into block RAM (optionally SYSREF-aligned)
// and serves them back 32 bits at a time with a fixed two-cycle read latency.
module adc_snapshot_buffer #(
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 1024,
  parameter int TS_WIDTH   = 32
) (
  input  logic                    aclk,
  input  logic                    arst,
  adc_snapshot_buffer_if.slave    bus,
  input  logic                    sysref_i,
  input  logic                    arm_i,
  input  logic                    align_i,
  input  logic                    abort_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [TS_WIDTH-1:0]     ts_o
);

  localparam int WPB    = DATA_WIDTH / 32;
  localparam int AW     = $clog2(DEPTH);
  localparam int RD_AW  = $clog2(DEPTH * WPB);
  localparam int WSEL_W = (WPB > 1) ? $clog2(WPB) : 1;
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t                state_r;
  state_t                state_nxt_s;
  logic                  busy_nxt_s;
  logic                  done_nxt_s;
  logic                  busy_r;
  logic                  done_r;

  logic                  tready_r;
  logic                  sysref_d_r;
  logic                  sysref_edge_s;
  logic                  arm_go_s;
  logic                  wr_en_s;
  logic [AW-1:0]         wr_ptr_r;
  logic [TS_WIDTH-1:0]   ts_cnt_r;
  logic [TS_WIDTH-1:0]   ts_r;

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [RD_AW-1:0]      rd_addr_s;
  logic [AW-1:0]         rd_beat_s;
  logic [WSEL_W-1:0]     rd_word_s;
  logic [DATA_WIDTH-1:0] ram_q_r;
  logic [WSEL_W-1:0]     rd_word_r;
  logic                  rd_pend_r;
  logic [31:0]           word_s;
  logic [31:0]           rd_data_r;
  logic                  rd_valid_r;

  // A capture may start only from a resting state, and abort always takes precedence.
  assign sysref_edge_s = sysref_i & ~sysref_d_r;
  assign arm_go_s      = arm_i & ~abort_i & ((state_r == ST_IDLE) | (state_r == ST_DONE));
  assign wr_en_s       = (state_r == ST_CAPTURE) & bus.s_axis_tvalid & ~abort_i;

  assign rd_addr_s = bus.rd_addr_i;
  assign rd_beat_s = AW'(rd_addr_s / RD_AW'(WPB));
  assign rd_word_s = WSEL_W'(rd_addr_s % RD_AW'(WPB));

  assign bus.s_axis_tready = tready_r;
  assign bus.rd_data_o     = rd_data_r;
  assign bus.rd_valid_o    = rd_valid_r;
  assign busy_o            = busy_r;
  assign done_o            = done_r;
  assign ts_o              = ts_r;

  // Capture FSM state register.
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Capture FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    if (abort_i) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (arm_i) begin
            state_nxt_s = align_i ? ST_WAIT : ST_CAPTURE;
          end else begin
            state_nxt_s = state_r;
          end
        end
        ST_WAIT: begin
          if (sysref_edge_s) begin
            state_nxt_s = ST_CAPTURE;
          end else begin
            state_nxt_s = ST_WAIT;
          end
        end
        ST_CAPTURE: begin
          if (wr_en_s && (wr_ptr_r == LAST_PTR)) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_CAPTURE;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
  end

  // Capture FSM output decode, taken from the next state so the registered flags track state_r.
  always_comb begin
    busy_nxt_s = 1'b0;
    done_nxt_s = 1'b0;
    case (state_nxt_s)
      ST_WAIT, ST_CAPTURE: busy_nxt_s = 1'b1;
      ST_DONE:             done_nxt_s = 1'b1;
      default: begin
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b0;
      end
    endcase
  end

  // Registered status outputs.
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= busy_nxt_s;
      done_r <= done_nxt_s;
    end
  end

  // Write pointer, timestamp counter/latch, SYSREF delay and stream ready.
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      tready_r   <= 1'b0;
      sysref_d_r <= 1'b0;
      ts_cnt_r   <= '0;
      ts_r       <= '0;
      wr_ptr_r   <= '0;
    end else begin
      tready_r   <= 1'b1;
      sysref_d_r <= sysref_i;
      ts_cnt_r   <= ts_cnt_r + TS_WIDTH'(1);
      if (arm_go_s) begin
        wr_ptr_r <= '0;
      end else if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (wr_en_s && (wr_ptr_r == '0)) begin
        ts_r <= ts_cnt_r;
      end
    end
  end

  // Snapshot RAM: write port plus read-first output register (no reset so it maps to block RAM).
  always_ff @(posedge aclk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= bus.s_axis_tdata;
    end
    if (bus.rd_en_i) begin
      ram_q_r   <= mem_r[rd_beat_s];
      rd_word_r <= rd_word_s;
    end
  end

  // 32-bit word select out of the registered RAM beat.
  always_comb begin
    word_s = 32'h0000_0000;
    for (int w = 0; w < WPB; w++) begin
      word_s = (rd_word_r == WSEL_W'(w)) ? ram_q_r[w*32 +: 32] : word_s;
    end
  end

  // Read pipeline valid tracking and output data register.
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      rd_pend_r  <= 1'b0;
      rd_valid_r <= 1'b0;
      rd_data_r  <= 32'h0000_0000;
    end else begin
      rd_pend_r  <= bus.rd_en_i;
      rd_valid_r <= rd_pend_r;
      if (rd_pend_r) begin
        rd_data_r <= word_s;
      end
    end
  end

endmodule

// File: tb/tb_adc_snapshot_buffer.sv
// Self-checking bench for adc_snapshot_buffer: capture modes, abort, async reset and read latency.
module tb_adc_snapshot_buffer;
  localparam int DW    = 128;
  localparam int DEPTH = 256;
  localparam int TSW   = 32;
  localparam int RAW   = 10;

  logic           aclk = 1'b0;
  logic           arst;
  logic           sysref_i, arm_i, align_i, abort_i;
  logic           busy_o, done_o;
  logic [TSW-1:0] ts_o;

  adc_snapshot_buffer_if #(.DATA_WIDTH(DW), .RD_ADDR_WIDTH(RAW)) bus_if ();

  adc_snapshot_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .TS_WIDTH(TSW)) dut (
    .aclk     (aclk),
    .arst     (arst),
    .bus      (bus_if),
    .sysref_i (sysref_i),
    .arm_i    (arm_i),
    .align_i  (align_i),
    .abort_i  (abort_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .ts_o     (ts_o)
  );

  always #5 aclk = ~aclk;

  typedef struct { logic [31:0] data; int due; } sb_t;
  typedef struct { logic [RAW-1:0] addr; logic [31:0] exp; } rd_vec_t;

  sb_t         sb_q[$];
  rd_vec_t     vecs [14];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] ts_model = 32'd0;
  logic [31:0] hold_exp = 32'd0;
  logic [31:0] exp_ts;

  function automatic logic [31:0] word_exp(input logic [7:0] seed, input int b, input int w);
    return {seed, 8'(w), 16'(b)};
  endfunction

  function automatic logic [DW-1:0] beat_data(input logic [7:0] seed, input int b);
    logic [DW-1:0] d;
    for (int w = 0; w < DW/32; w++) d[w*32 +: 32] = word_exp(seed, b, w);
    return d;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic sb_check();
    sb_t e;
    if (bus_if.rd_valid_o === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected: got valid data %0h expected no result (cycle %0d)", bus_if.rd_data_o, cyc);
      end else begin
        e = sb_q.pop_front();
        check("rd_data", bus_if.rd_data_o, e.data);
        check("rd_latency", cyc, e.due);
        hold_exp = e.data;
      end
    end else begin
      check("rd_hold", bus_if.rd_data_o, hold_exp);
      if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
        checks++;
        errors++;
        $display("FAIL rd_missing: got no valid expected %0h due cycle %0d (cycle %0d)", sb_q[0].data, sb_q[0].due, cyc);
        e = sb_q.pop_front();
      end
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
    cyc++;
    ts_model++;
    sb_check();
  endtask

  task automatic issue_read(input logic [RAW-1:0] a, input logic [31:0] d);
    bus_if.rd_en_i   = 1'b1;
    bus_if.rd_addr_i = a;
    sb_q.push_back('{data: d, due: cyc + 2});
  endtask

  task automatic read_word(input logic [7:0] seed, input int b, input int w);
    issue_read(RAW'(4*b + w), word_exp(seed, b, w));
    tick();
    bus_if.rd_en_i = 1'b0;
  endtask

  task automatic drain();
    bus_if.rd_en_i = 1'b0;
    repeat (3) tick();
  endtask

  task automatic capture(input logic [7:0] seed, input int first, input int n);
    for (int i = 0; i < n; i++) begin
      bus_if.s_axis_tdata  = beat_data(seed, first + i);
      bus_if.s_axis_tvalid = 1'b1;
      tick();
    end
    bus_if.s_axis_tvalid = 1'b0;
  endtask

  task automatic arm_cmd(input logic align);
    arm_i   = 1'b1;
    align_i = align;
    tick();
    arm_i   = 1'b0;
    align_i = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{10'd0,    32'h5500_0000};
    vecs[1]  = '{10'd1,    32'h5501_0000};
    vecs[2]  = '{10'd2,    32'h5502_0000};
    vecs[3]  = '{10'd3,    32'h5503_0000};
    vecs[4]  = '{10'd4,    32'h5500_0001};
    vecs[5]  = '{10'd5,    32'h5501_0001};
    vecs[6]  = '{10'd6,    32'h5502_0001};
    vecs[7]  = '{10'd7,    32'h5503_0001};
    vecs[8]  = '{10'd400,  32'h5500_0064};
    vecs[9]  = '{10'd513,  32'h5501_0080};
    vecs[10] = '{10'd1020, 32'h5500_00FF};
    vecs[11] = '{10'd1021, 32'h5501_00FF};
    vecs[12] = '{10'd1022, 32'h5502_00FF};
    vecs[13] = '{10'd1023, 32'h5503_00FF};

    arst = 1'b1;
    sysref_i = 1'b0; arm_i = 1'b0; align_i = 1'b0; abort_i = 1'b0;
    bus_if.s_axis_tdata = '0; bus_if.s_axis_tvalid = 1'b0;
    bus_if.rd_en_i = 1'b0; bus_if.rd_addr_i = '0;
    #1;
    check("rst_tready", bus_if.s_axis_tready, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_done", done_o, 1'b0);
    check("rst_ts", ts_o, 32'd0);
    check("rst_rd_valid", bus_if.rd_valid_o, 1'b0);
    check("rst_rd_data", bus_if.rd_data_o, 32'd0);
    repeat (2) tick();
    arst = 1'b0;
    ts_model = 32'd0;
    tick();
    check("tready_up", bus_if.s_axis_tready, 1'b1);
    check("idle_busy", busy_o, 1'b0);

    // 1: immediate capture, continuous valid
    arm_cmd(1'b0);
    check("t1_busy", busy_o, 1'b1);
    exp_ts = ts_model;
    capture(8'h11, 0, DEPTH - 1);
    check("t1_done_early", done_o, 1'b0);
    capture(8'h11, DEPTH - 1, 1);
    check("t1_done", done_o, 1'b1);
    check("t1_busy_end", busy_o, 1'b0);
    check("t1_ts", ts_o, exp_ts);
    for (int b = 0; b < DEPTH; b++) read_word(8'h11, b, 0);
    for (int w = 1; w < 4; w++) begin
      read_word(8'h11, 7, w);
      read_word(8'h11, 200, w);
    end
    drain();

    // 2: SYSREF-aligned capture; arm while waiting is ignored
    arm_cmd(1'b1);
    check("t2_busy", busy_o, 1'b1);
    check("t2_done_drop", done_o, 1'b0);
    for (int i = 0; i < 36; i++) begin
      bus_if.s_axis_tdata  = beat_data(8'hEE, i);
      bus_if.s_axis_tvalid = 1'b1;
      arm_i = (i == 10);
      tick();
      arm_i = 1'b0;
    end
    check("t2_wait_busy", busy_o, 1'b1);
    sysref_i = 1'b1;
    bus_if.s_axis_tdata = beat_data(8'hEE, 36);
    tick();
    check("t2_edge_busy", busy_o, 1'b1);
    exp_ts = ts_model;
    capture(8'h22, 0, DEPTH - 1);
    check("t2_done_early", done_o, 1'b0);
    capture(8'h22, DEPTH - 1, 1);
    sysref_i = 1'b0;
    check("t2_done", done_o, 1'b1);
    check("t2_ts", ts_o, exp_ts);
    read_word(8'h22, 0, 0);
    read_word(8'h22, 0, 3);
    read_word(8'h22, 1, 0);
    read_word(8'h22, 255, 2);
    drain();

    // 3: valid toggling 1010..., re-armed from DONE
    arm_cmd(1'b0);
    check("t3_done_drop", done_o, 1'b0);
    check("t3_busy", busy_o, 1'b1);
    for (int b = 0; b < DEPTH; b++) begin
      bus_if.s_axis_tdata  = beat_data(8'h33, b);
      bus_if.s_axis_tvalid = 1'b1;
      tick();
      check("t3_done", done_o, (b == DEPTH - 1) ? 1'b1 : 1'b0);
      bus_if.s_axis_tdata  = beat_data(8'hCC, b);
      bus_if.s_axis_tvalid = 1'b0;
      tick();
    end
    for (int b = 0; b < 4; b++) read_word(8'h33, b, b);
    read_word(8'h33, 128, 0);
    read_word(8'h33, 255, 3);
    drain();

    // 4: abort mid-capture, abort beats arm, then a fresh capture
    arm_cmd(1'b0);
    capture(8'h44, 0, 100);
    abort_i = 1'b1;
    bus_if.s_axis_tdata  = beat_data(8'h44, 100);
    bus_if.s_axis_tvalid = 1'b1;
    tick();
    abort_i = 1'b0;
    bus_if.s_axis_tvalid = 1'b0;
    check("t4_abort_busy", busy_o, 1'b0);
    check("t4_abort_done", done_o, 1'b0);
    read_word(8'h44, 50, 1);
    read_word(8'h44, 99, 3);
    read_word(8'h33, 150, 2);
    drain();
    arm_i = 1'b1; abort_i = 1'b1;
    tick();
    arm_i = 1'b0; abort_i = 1'b0;
    check("t4_abort_wins", busy_o, 1'b0);
    arm_cmd(1'b0);
    check("t4_rearm_busy", busy_o, 1'b1);
    capture(8'h4B, 0, DEPTH);
    check("t4_done", done_o, 1'b1);
    read_word(8'h4B, 0, 0);
    read_word(8'h4B, 100, 1);
    read_word(8'h4B, 150, 2);
    drain();
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    check("t4_abort_clears_done", done_o, 1'b0);

    // 5: asynchronous reset in the middle of a capture with reads in flight
    arm_cmd(1'b0);
    capture(8'h5A, 0, 20);
    for (int i = 0; i < 4; i++) begin
      bus_if.s_axis_tdata  = beat_data(8'h5A, 20 + i);
      bus_if.s_axis_tvalid = 1'b1;
      issue_read(RAW'(i), word_exp(8'h5A, 0, i));
      tick();
    end
    check("t5_pre_busy", busy_o, 1'b1);
    check("t5_pre_rd_valid", bus_if.rd_valid_o, 1'b1);
    #3;
    arst = 1'b1;
    #1;
    check("t5_busy", busy_o, 1'b0);
    check("t5_done", done_o, 1'b0);
    check("t5_rd_valid", bus_if.rd_valid_o, 1'b0);
    check("t5_rd_data", bus_if.rd_data_o, 32'd0);
    check("t5_ts", ts_o, 32'd0);
    check("t5_tready", bus_if.s_axis_tready, 1'b0);
    sb_q.delete();
    hold_exp = 32'd0;
    bus_if.rd_en_i = 1'b0;
    bus_if.s_axis_tvalid = 1'b0;
    repeat (2) tick();
    arst = 1'b0;
    ts_model = 32'd0;
    tick();
    check("t5_tready_up", bus_if.s_axis_tready, 1'b1);
    check("t5_idle_busy", busy_o, 1'b0);
    arm_cmd(1'b0);
    check("t5_rearm_busy", busy_o, 1'b1);
    exp_ts = ts_model;
    capture(8'h55, 0, DEPTH);
    check("t5_done_after", done_o, 1'b1);
    check("t5_ts_after", ts_o, exp_ts);

    // 6: back-to-back reads from the vector table
    for (int k = 0; k < 14; k++) begin
      issue_read(vecs[k].addr, vecs[k].exp);
      tick();
    end
    drain();
    check("sb_empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
